// File: rtl/mem_arbiter.sv
// mem_arbiter: grants main memory to one of two cache controllers
// (0 = instruction side, 1 = data side). The owner's access is forwarded
// combinationally. Read returns are tracked in a MEM_LAT-deep {valid, owner}
// pipe, so data always reaches the requester that issued the read.
module mem_arbiter #(
    parameter int MEM_LAT  = 2,
    parameter int HOLD_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_rd,
    input  logic        req0_wr,
    input  logic        req0_lock,
    input  logic [15:0] req0_addr,
    input  logic [15:0] req0_wdata,
    input  logic        req1_rd,
    input  logic        req1_wr,
    input  logic        req1_lock,
    input  logic [15:0] req1_addr,
    input  logic [15:0] req1_wdata,
    output logic        gnt0,
    output logic        gnt1,
    output logic        stall0,
    output logic        stall1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [15:0] rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_stall,
    output logic        err
);
    localparam int HW = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               last_gnt_q, last_gnt_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [MEM_LAT-1:0] pv_q, pv_d;     // read-return pipe: valid bits
    logic [MEM_LAT-1:0] po_q, po_d;     // read-return pipe: issuing requester

    logic        req0_s, req1_s;
    logic        owning_s, own_idx_s, own_rd_s, own_wr_s, own_lock_s, oth_req_s;
    logic [15:0] own_addr_s, own_wdata_s;
    logic        proto_err_s, hold_force_s, fwd_rd_s, fwd_wr_s, acc_rd_s;

    assign req0_s = req0_rd | req0_wr;
    assign req1_s = req1_rd | req1_wr;

    // Select the current owner's request lines; the non-owner is ignored.
    always_comb begin
        owning_s    = 1'b0;
        own_idx_s   = 1'b0;
        own_rd_s    = 1'b0;
        own_wr_s    = 1'b0;
        own_lock_s  = 1'b0;
        own_addr_s  = 16'h0000;
        own_wdata_s = 16'h0000;
        oth_req_s   = 1'b0;
        case (state_q)
            OWN0: begin
                owning_s    = 1'b1;
                own_idx_s   = 1'b0;
                own_rd_s    = req0_rd;
                own_wr_s    = req0_wr;
                own_lock_s  = req0_lock;
                own_addr_s  = req0_addr;
                own_wdata_s = req0_wdata;
                oth_req_s   = req1_s;
            end
            OWN1: begin
                owning_s    = 1'b1;
                own_idx_s   = 1'b1;
                own_rd_s    = req1_rd;
                own_wr_s    = req1_wr;
                own_lock_s  = req1_lock;
                own_addr_s  = req1_addr;
                own_wdata_s = req1_wdata;
                oth_req_s   = req0_s;
            end
            default: begin
                owning_s = 1'b0;
            end
        endcase
    end

    // rd and wr together is illegal: forward neither. The hold limit fires
    // on the HOLD_MAX-th owner cycle in which the other side is waiting.
    assign proto_err_s  = owning_s & own_rd_s & own_wr_s;
    assign fwd_rd_s     = owning_s & own_rd_s & ~own_wr_s;
    assign fwd_wr_s     = owning_s & own_wr_s & ~own_rd_s;
    assign acc_rd_s     = fwd_rd_s & ~mem_stall;
    assign hold_force_s = owning_s & oth_req_s & (hold_q == HW'(HOLD_MAX - 1));

    // Shift the read-return pipe; stage 0 captures this cycle's accepted read.
    always_comb begin
        pv_d    = '0;
        po_d    = '0;
        pv_d[0] = acc_rd_s;
        po_d[0] = own_idx_s;
        for (int i = 1; i < MEM_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            po_d[i] = po_q[i-1];
        end
    end

    // Next ownership state, round-robin memory and hold counter.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        hold_d     = '0;
        case (state_q)
            IDLE: begin
                if (req0_s && req1_s) begin
                    if (last_gnt_q) begin
                        state_d    = OWN0;
                        last_gnt_d = 1'b0;
                    end else begin
                        state_d    = OWN1;
                        last_gnt_d = 1'b1;
                    end
                end else if (req0_s) begin
                    state_d    = OWN0;
                    last_gnt_d = 1'b0;
                end else if (req1_s) begin
                    state_d    = OWN1;
                    last_gnt_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN0, OWN1: begin
                if (hold_force_s || !(own_lock_s || own_rd_s || own_wr_s)) begin
                    // |pv_d: reads still in flight once this cycle completes
                    state_d = (|pv_d) ? DRAIN : IDLE;
                    hold_d  = '0;
                end else if (oth_req_s) begin
                    hold_d = hold_q + HW'(1);
                end else begin
                    hold_d = hold_q;
                end
            end
            DRAIN: begin
                if (!(|pv_d)) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pipe and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            hold_q     <= '0;
            pv_q       <= '0;
            po_q       <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            hold_q     <= hold_d;
            pv_q       <= pv_d;
            po_q       <= po_d;
        end
    end

    // Grant, stall, forwarding, read return and error outputs.
    always_comb begin
        gnt0      = (state_q == OWN0);
        gnt1      = (state_q == OWN1);
        stall0    = req0_s & (~gnt0 | mem_stall | proto_err_s);
        stall1    = req1_s & (~gnt1 | mem_stall | proto_err_s);
        mem_rd    = fwd_rd_s;
        mem_wr    = fwd_wr_s;
        mem_addr  = own_addr_s;
        mem_wdata = own_wdata_s;
        rvalid0   = pv_q[MEM_LAT-1] & ~po_q[MEM_LAT-1];
        rvalid1   = pv_q[MEM_LAT-1] &  po_q[MEM_LAT-1];
        rdata     = pv_q[MEM_LAT-1] ? mem_rdata : 16'h0000;
        err       = proto_err_s | hold_force_s;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic,
// checked against a cycle-level ownership model and a read-return scoreboard.
module tb_mem_arbiter;
    localparam int MEM_LAT  = 2;
    localparam int HOLD_MAX = 16;
    localparam int FREE     = -1;
    localparam int DRAINING = 2;

    logic        clk;
    logic        rst;
    logic        req0_rd, req0_wr, req0_lock;
    logic [15:0] req0_addr, req0_wdata;
    logic        req1_rd, req1_wr, req1_lock;
    logic [15:0] req1_addr, req1_wdata;
    logic        gnt0, gnt1, stall0, stall1, rvalid0, rvalid1;
    logic [15:0] rdata;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_stall;
    logic        err;

    mem_arbiter #(.MEM_LAT(MEM_LAT), .HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .rst(rst),
        .req0_rd(req0_rd), .req0_wr(req0_wr), .req0_lock(req0_lock),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_rd(req1_rd), .req1_wr(req1_wr), .req1_lock(req1_lock),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .gnt0(gnt0), .gnt1(gnt1), .stall0(stall0), .stall1(stall1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .err(err)
    );

    typedef struct packed {
        logic        rst_n;
        logic        r0rd, r0wr, r0lk;
        logic [15:0] r0a, r0d;
        logic        r1rd, r1wr, r1lk;
        logic [15:0] r1a, r1d;
        logic        mst;
    } stim_t;

    typedef struct { int id; int due; logic [15:0] data; } exp_t;
    typedef struct { int due; logic [15:0] addr; } mreq_t;

    stim_t st;
    exp_t  sb[$];        // expected read returns, in order
    int    inflight[$];  // return cycles of reads the model has accepted
    mreq_t mq[$];        // memory-side pending reads
    int    cyc = 0;
    int    n_checks = 0;
    int    n_err = 0;
    // reference model state
    int    owner = FREE;
    int    prefer = 0;
    int    waited = 0;
    logic  post_rst = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%b expected=%b", nm, cyc, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Memory: records every accepted read and answers MEM_LAT cycles later.
    initial forever begin
        @(negedge clk);
        if (mq.size() > 0 && mq[0].due <= cyc) void'(mq.pop_front());
        if (mem_rd && !mem_stall) mq.push_back('{cyc + MEM_LAT, mem_addr});
    end

    initial begin
        mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (mq.size() > 0 && mq[0].due == cyc) mem_rdata = memf(mq[0].addr);
            else mem_rdata = 16'($urandom);
        end
    end

    // Monitor: every cycle, the read return (or its absence) must match the scoreboard head.
    initial forever begin
        logic e;
        @(negedge clk);
        e = (sb.size() > 0 && sb[0].due == cyc);
        chk1("rvalid_present", rvalid0 | rvalid1, e);
        if (e) begin
            chk1("rvalid0", rvalid0, sb[0].id == 0);
            chk1("rvalid1", rvalid1, sb[0].id == 1);
            chk16("rdata", rdata, sb[0].data);
            void'(sb.pop_front());
        end else begin
            chk16("rdata_idle", rdata, 16'h0000);
        end
    end

    // Reference model: apply the arbitration rules for one cycle.
    task automatic model_cycle();
        logic ord, owr, olk, oth, bad, forced, e_rd, e_wr, r0, r1;
        logic [15:0] oad, owd;
        int o, still;
        exp_t keep[$];
        o  = owner;
        r0 = st.r0rd | st.r0wr;
        r1 = st.r1rd | st.r1wr;
        ord = 1'b0; owr = 1'b0; olk = 1'b0; oth = 1'b0; oad = 16'h0000; owd = 16'h0000;
        if (o == 0) begin
            ord = st.r0rd; owr = st.r0wr; olk = st.r0lk; oad = st.r0a; owd = st.r0d; oth = r1;
        end else if (o == 1) begin
            ord = st.r1rd; owr = st.r1wr; olk = st.r1lk; oad = st.r1a; owd = st.r1d; oth = r0;
        end
        bad    = ord & owr;
        e_rd   = ord & ~owr;
        e_wr   = owr & ~ord;
        forced = oth && (waited + 1 == HOLD_MAX);

        chk1("gnt0", gnt0, o == 0);
        chk1("gnt1", gnt1, o == 1);
        chk1("stall0", stall0, r0 & ((o != 0) | st.mst | bad));
        chk1("stall1", stall1, r1 & ((o != 1) | st.mst | bad));
        chk1("mem_rd", mem_rd, e_rd);
        chk1("mem_wr", mem_wr, e_wr);
        chk1("err", err, bad | forced);
        if (o == 0 || o == 1 || post_rst) begin
            chk16("mem_addr", mem_addr, oad);
            chk16("mem_wdata", mem_wdata, owd);
        end

        if (e_rd && !st.mst) begin
            sb.push_back('{o, cyc + MEM_LAT, memf(oad)});
            inflight.push_back(cyc + MEM_LAT);
        end

        if (!st.rst_n) begin
            owner = FREE; prefer = 0; waited = 0; post_rst = 1'b1;
            inflight.delete();
            foreach (sb[i]) if (sb[i].due <= cyc) keep.push_back(sb[i]);
            sb = keep;
        end else begin
            post_rst = 1'b0;
            while (inflight.size() > 0 && inflight[0] <= cyc) void'(inflight.pop_front());
            still = inflight.size();
            if (o == 0 || o == 1) begin
                if (forced || !(olk | ord | owr)) begin
                    owner  = (still > 0) ? DRAINING : FREE;
                    waited = 0;
                end else if (oth) begin
                    waited++;
                end
            end else if (o == DRAINING) begin
                if (still == 0) owner = FREE;
            end else if (r0 | r1) begin
                owner  = (r0 & r1) ? prefer : (r0 ? 0 : 1);
                prefer = 1 - owner;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rst = st.rst_n;
        req0_rd = st.r0rd; req0_wr = st.r0wr; req0_lock = st.r0lk;
        req0_addr = st.r0a; req0_wdata = st.r0d;
        req1_rd = st.r1rd; req1_wr = st.r1wr; req1_lock = st.r1lk;
        req1_addr = st.r1a; req1_wdata = st.r1d;
        mem_stall = st.mst;
        @(negedge clk);
        model_cycle();
    endtask

    task automatic idle(input int n);
        st = '0;
        st.rst_n = 1'b1;
        repeat (n) step();
    endtask

    task automatic do_reset();
        st = '0;
        step();
        st.rst_n = 1'b1;
    endtask

    initial begin
        st = '0;
        rst = 1'b0;
        req0_rd = 1'b0; req0_wr = 1'b0; req0_lock = 1'b0; req0_addr = 16'h0; req0_wdata = 16'h0;
        req1_rd = 1'b0; req1_wr = 1'b0; req1_lock = 1'b0; req1_addr = 16'h0; req1_wdata = 16'h0;
        mem_stall = 1'b0;
        do_reset();
        do_reset();
        idle(1);

        // single read 0x1234 from requester 0
        st.r0rd = 1'b1; st.r0a = 16'h1234;
        step(); step();
        idle(5);

        // contention after reset, then contention again
        do_reset();
        st.r0rd = 1'b1; st.r0a = 16'h0A00; st.r1rd = 1'b1; st.r1a = 16'h0B00;
        step(); step(); step();
        st.r0rd = 1'b0;
        step(); step();
        idle(4);
        st.r0rd = 1'b1; st.r0a = 16'h0A10; st.r1wr = 1'b1; st.r1a = 16'h0B10; st.r1d = 16'hBEEF;
        step(); step(); step();
        idle(5);

        // requester 1 locked for 4 writes + 4 reads while requester 0 waits
        st.r1wr = 1'b1; st.r1lk = 1'b1; st.r1a = 16'h0100; st.r1d = 16'h1111;
        step();
        st.r0rd = 1'b1; st.r0a = 16'h0200;
        for (int i = 0; i < 8; i++) begin
            st.r1wr = (i < 4); st.r1rd = (i >= 4);
            st.r1a = 16'h0100 + 16'(i); st.r1d = 16'h1111 + 16'(i);
            step();
        end
        st.r1rd = 1'b0; st.r1wr = 1'b0; st.r1lk = 1'b0;
        repeat (7) step();
        idle(5);

        // read returns follow the issuer after ownership moves
        do_reset();
        st.r0rd = 1'b1; st.r0a = 16'h4444;
        step(); step();
        st.r0rd = 1'b0; st.r1rd = 1'b1; st.r1a = 16'h5555;
        repeat (5) step();
        idle(5);

        // requester 0 locked 20 cycles with requester 1 waiting: hold limit
        do_reset();
        st.r0wr = 1'b1; st.r0lk = 1'b1; st.r0a = 16'h0600; st.r0d = 16'h0060;
        step();
        for (int i = 0; i < 24; i++) begin
            st.r0lk = (i < 20); st.r0wr = (i < 20) && (i % 2 == 0);
            st.r1rd = 1'b1; st.r1a = 16'h0700 + 16'(i);
            step();
        end
        idle(5);

        // reset one cycle after an accepted read discards the return
        st.r0rd = 1'b1; st.r0a = 16'h3333;
        step(); step();
        do_reset();
        idle(4);

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            st.rst_n = ($urandom_range(63) != 0);
            st.r0rd = ($urandom_range(2) == 0); st.r0wr = ($urandom_range(4) == 0);
            st.r0lk = ($urandom_range(4) == 0);
            st.r0a = 16'($urandom); st.r0d = 16'($urandom);
            st.r1rd = ($urandom_range(2) == 0); st.r1wr = ($urandom_range(4) == 0);
            st.r1lk = ($urandom_range(4) == 0);
            st.r1a = 16'($urandom); st.r1d = 16'($urandom);
            st.mst = ($urandom_range(3) == 0);
            step();
        end
        idle(8);
        chk1("scoreboard_empty", sb.size() == 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_LAT, default 2, giving main-memory read latency in cycles from accepted mem_rd to valid mem_data_in.
REQ-002 The block SHALL have parameter HOLD_MAX, default 16, giving the maximum cycles one requester may hold the grant while the other waits.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-005 reqN_rd, reqN_wr (N=0,1)  in  1 each  read/write request from cache controller N (0 = instruction side, 1 = data side).
REQ-006 reqN_lock  in  1  requester N holds ownership across a multi-cycle sequence (writeback plus allocate).
REQ-007 reqN_addr, reqN_wdata  in  16 each  request address and write data.
REQ-008 gntN  out  1  requester N currently owns memory.
REQ-009 stallN  out  1  requester N must hold its request this cycle.
REQ-010 rvalidN  out  1  rdata carries the read return for requester N.
REQ-011 rdata  out  16  read return data, shared by both requesters.
REQ-012 mem_rd, mem_wr  out  1 each; mem_addr, mem_wdata  out  16 each: forwarded access to main memory.
REQ-013 mem_rdata  in  16; mem_stall  in  1: memory read data and bank-busy.
REQ-014 err  out  1  protocol/timeout error flag.

Function
REQ-015 The FSM SHALL have states IDLE, OWN0, OWN1 and DRAIN.
REQ-016 In IDLE, with any reqN_rd|reqN_wr, the FSM SHALL go to OWNn next cycle: sole requester wins; both requesting, the requester other than last_gnt wins.
REQ-017 last_gnt SHALL be a 1-bit register updated to n on every IDLE->OWNn transition.
REQ-018 A request seen in IDLE SHALL NOT be forwarded; the requester is stalled for that cycle (grant latency = 1 cycle).
REQ-019 In OWNn, gntn=1 and mem_rd/mem_wr/mem_addr/mem_wdata SHALL equal requester n's inputs combinationally; the other requester's inputs SHALL be ignored.
REQ-020 An access SHALL be accepted when forwarded with mem_stall=0.
REQ-021 stallN SHALL equal (reqN_rd|reqN_wr) & (~gntN | mem_stall).
REQ-022 OWNn SHALL persist while reqn_lock=1 or requester n has a request; otherwise it goes to DRAIN if reads are outstanding, else IDLE.
REQ-023 DRAIN SHALL forward nothing and go to IDLE in the cycle the outstanding-read count reaches 0.
REQ-024 A MEM_LAT-deep pipe of {valid, owner} SHALL be loaded with {1, n} on each accepted read and {0, x} otherwise.
REQ-025 At the pipe output, rvalid[owner]=valid and rdata=mem_rdata; rdata=0 when no output is valid.
REQ-026 Read returns SHALL reach the issuing requester even after ownership changes.
REQ-027 If the owner asserts rd and wr together, the block SHALL forward neither, assert err that cycle and stall the owner.
REQ-028 A hold counter SHALL count OWNn cycles in which the non-owner requests and SHALL clear on leaving OWNn.
REQ-029 At count = HOLD_MAX, ownership SHALL be forced to DRAIN/IDLE regardless of lock, and err SHALL pulse for one cycle.
REQ-030 Writes SHALL produce no rvalid.

Reset
REQ-031 With rst=0 at a clock edge, the block SHALL enter IDLE with last_gnt=1, the pipe and hold counter cleared, and all outputs 0 the following cycle.
REQ-032 Reset mid-transaction SHALL discard outstanding reads; no rvalid SHALL be issued for pre-reset accesses.

Verification
REQ-033 Req0 read 0x1234 alone -> gnt0 at cycle 1, mem_rd with mem_addr=0x1234 at cycle 1, rvalid0 with rdata=mem_rdata at cycle 3.
REQ-034 Req0 and req1 both request in IDLE after reset -> req0 granted first; next contention -> req1 granted.
REQ-035 Req1 lock held for 8 cycles (4 writes, 4 reads) while req0 requests -> req0 stalled throughout, gnt0 only after lock drops and the 4th read returns.
REQ-036 Req0 read accepted, then req0 releases and req1 is granted -> returning data raises rvalid0, never rvalid1.
REQ-037 Req0 lock held 20 cycles with req1 waiting -> err pulse at wait count 16, req1 granted afterward.
REQ-038 rst=0 one cycle after an accepted read -> no rvalid in the following 3 cycles, all outputs 0.
